nibble_adder_arbiter: RTL

Shares a single 4-bit ripple-carry adder (fourBitAdder) between two requesters. It performs WIDTH-bit add/subtract operations nibble-serially, one nibble per cycle, and holds the inter-nibble carry in a register. Requesters are arbitrated round-robin with valid/ready handshakes. One result port returns the sum, carry-out and the requester ID.

---
 rtl/nibble_adder_pkg.sv | 12 +
 rtl/nibble_adder_arbiter_fourbitadder.sv | 21 ++
 rtl/nibble_adder_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/nibble_adder_pkg.sv
// rtl/nibble_adder_pkg.sv - shared constants and FSM state type for the nibble-serial adder
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_adder_arbiter_fourbitadder.sv
// rtl/nibble_adder_arbiter_fourbitadder.sv - 4-bit ripple-carry adder shared by both requesters
module fourBitAdder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[4];

endmodule

// File: rtl/nibble_adder_arbiter.sv
// rtl/nibble_adder_arbiter.sv - round-robin shared nibble-serial WIDTH-bit add/subtract unit
module nibble_adder_arbiter
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_id
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t           r_state;
  logic             r_rr_ptr;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_sum;
  logic             r_res_carry;

  logic                w_grant;
  logic                w_hs;
  logic                w_sub;
  logic [WIDTH-1:0]    w_a;
  logic [WIDTH-1:0]    w_b;
  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_sum;
  logic                w_cout;

  // Contention goes to the requester named by the round-robin pointer.
  assign w_grant = (req0_valid && req1_valid) ? r_rr_ptr : req1_valid;

  assign req0_ready = rst_n && (r_state == IDLE) && req0_valid && !w_grant;
  assign req1_ready = rst_n && (r_state == IDLE) && req1_valid &&  w_grant;
  assign w_hs       = req0_ready || req1_ready;

  assign w_sub = w_grant ? req1_sub : req0_sub;
  assign w_a   = w_grant ? req1_a   : req0_a;
  assign w_b   = w_grant ? req1_b   : req0_b;

  assign w_a_nib = r_a[r_cnt*NIBBLE_W +: NIBBLE_W];
  assign w_b_nib = r_b[r_cnt*NIBBLE_W +: NIBBLE_W];

  fourBitAdder u_adder (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= 1'b0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_id        <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_carry <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            // Subtract is A + ~B + 1: invert B here and seed the carry with sub.
            r_a     <= w_a;
            r_b     <= w_b ^ {WIDTH{w_sub}};
            r_id    <= w_grant;
            r_carry <= w_sub;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_res_sum[r_cnt*NIBBLE_W +: NIBBLE_W] <= w_sum;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(NIBBLES - 1)) begin
            r_res_carry <= w_cout;
            r_res_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_rr_ptr    <= ~r_id;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_sum   = r_res_sum;
  assign res_carry = r_res_carry;
  assign res_id    = r_id;

endmodule
